// File: rtl/sprite_pkg.sv
// Shared sprite definitions: DMA state encodings and sprite attribute RAM geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_ARMED,
        DMA_COPY,
        DMA_FLUSH,
        DMA_DONE
    } dma_state_t;

    localparam int SPR_COUNT          = 32;
    localparam int SPR_RAM_ITEM_WIDTH = 4;
    localparam int SPR_XFER_LEN       = SPR_COUNT * SPR_RAM_ITEM_WIDTH;

endpackage

// File: rtl/sprite_dma_edge.sv
// Registered rising-edge detector for vblank.
// Latency: rise is combinational from vblank against the previous-cycle sample.
// Backpressure: none.
module sprite_dma_edge (
    input  logic clk,
    input  logic reset,
    input  logic vblank,
    output logic vblank_rise
);

    logic vblank_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_last <= 1'b0;
        end else begin
            vblank_last <= vblank;
        end
    end

    assign vblank_rise = vblank & ~vblank_last;

endmodule

// File: rtl/sprite_dma.sv
// Copies a work-RAM shadow table into sprite RAM on vblank rise; SPRITE_DMA_AUTO_EN re-arms every frame.
// Latency: first write 2 cycles after vblank rise, dma_done pulses XFER_LEN+2 cycles after it.
// Backpressure: none; one byte per cycle, both RAM ports always accept.
module sprite_dma
    import sprite_pkg::*;
#(
    parameter int SRC_AW   = 16,
    parameter int DST_AW   = 7,
    parameter int XFER_LEN = SPR_XFER_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vblank,
    input  logic              cpu_start,
    input  logic [SRC_AW-1:0] cpu_src_base,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic [DST_AW-1:0] spriteram_wr_addr,
    output logic [7:0]        spriteram_data_in,
    output logic              spriteram_wr,
    output logic              dma_armed,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              dma_overrun
);

    localparam logic [DST_AW-1:0] LAST_IDX = DST_AW'(XFER_LEN - 1);

    dma_state_t        state;
    logic [SRC_AW-1:0] base;
    logic [DST_AW-1:0] rd_idx;
    logic [SRC_AW-1:0] arm_base;
    logic              vblank_rise;
    logic              disarm;

    sprite_dma_edge u_edge (
        .clk         (clk),
        .reset       (reset),
        .vblank      (vblank),
        .vblank_rise (vblank_rise)
    );

`ifdef SPRITE_DMA_AUTO_EN
    assign disarm = cpu_start && (cpu_src_base == '0);
`else
    assign disarm = 1'b0;
`endif

    // A strobe coinciding with the vblank edge must win over the older base.
    assign arm_base = cpu_start ? cpu_src_base : base;

    // Read data arrives the cycle the write is presented, so it passes straight through.
    assign spriteram_data_in = spriteram_wr ? src_data : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= DMA_IDLE;
            base              <= '0;
            rd_idx            <= '0;
            src_addr          <= '0;
            spriteram_wr_addr <= '0;
            spriteram_wr      <= 1'b0;
            dma_armed         <= 1'b0;
            dma_busy          <= 1'b0;
            dma_done          <= 1'b0;
            dma_overrun       <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            if (cpu_start) begin
                dma_overrun <= 1'b0;
            end
            if ((state == DMA_COPY || state == DMA_FLUSH) && !vblank) begin
                dma_overrun <= 1'b1;
            end

            case (state)
                DMA_IDLE: begin
                    if (cpu_start && !disarm) begin
                        base      <= cpu_src_base;
                        dma_armed <= 1'b1;
                        state     <= DMA_ARMED;
                    end
                end
                DMA_ARMED: begin
                    if (disarm) begin
                        dma_armed <= 1'b0;
                        state     <= DMA_IDLE;
                    end else if (vblank_rise) begin
                        base      <= arm_base;
                        src_addr  <= arm_base;
                        rd_idx    <= '0;
                        dma_armed <= 1'b0;
                        dma_busy  <= 1'b1;
                        state     <= DMA_COPY;
                    end else if (cpu_start) begin
                        base <= cpu_src_base;
                    end
                end
                DMA_COPY: begin
                    // rd_idx tracks the byte whose address is on src_addr this cycle.
                    spriteram_wr      <= 1'b1;
                    spriteram_wr_addr <= rd_idx;
                    if (rd_idx == LAST_IDX) begin
                        state <= DMA_FLUSH;
                    end else begin
                        src_addr <= src_addr + SRC_AW'(1);
                        rd_idx   <= rd_idx + DST_AW'(1);
                    end
                end
                DMA_FLUSH: begin
                    spriteram_wr <= 1'b0;
                    dma_busy     <= 1'b0;
                    dma_done     <= 1'b1;
                    state        <= DMA_DONE;
                end
                DMA_DONE: begin
`ifdef SPRITE_DMA_AUTO_EN
                    dma_armed <= 1'b1;
                    state     <= DMA_ARMED;
`else
                    state     <= DMA_IDLE;
`endif
                end
                default: begin
                    state <= DMA_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_dma.sv
// Scoreboard bench for sprite_dma: stimulus pushes expected sprite RAM writes, a monitor pops and compares.
module tb_sprite_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic        cpu_start = 1'b0;
    logic [15:0] cpu_src_base = '0;
    logic [15:0] src_addr;
    logic [7:0]  src_data = '0;
    logic [6:0]  spriteram_wr_addr;
    logic [7:0]  spriteram_data_in;
    logic        spriteram_wr;
    logic        dma_armed;
    logic        dma_busy;
    logic        dma_done;
    logic        dma_overrun;

    sprite_dma dut (
        .clk               (clk),
        .reset             (reset),
        .vblank            (vblank),
        .cpu_start         (cpu_start),
        .cpu_src_base      (cpu_src_base),
        .src_addr          (src_addr),
        .src_data          (src_data),
        .spriteram_wr_addr (spriteram_wr_addr),
        .spriteram_data_in (spriteram_data_in),
        .spriteram_wr      (spriteram_wr),
        .dma_armed         (dma_armed),
        .dma_busy          (dma_busy),
        .dma_done          (dma_done),
        .dma_overrun       (dma_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [0:65535];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         n_wr = 0;
    int         first_wr = -1;
    int         last_wr = -1;
    int         done_cnt = 0;
    int         done_cyc = -1;

    // Synchronous work RAM: data valid the cycle after the address.
    always @(posedge clk) src_data <= mem[src_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented write is matched against the scoreboard head.
    always @(negedge clk) begin
        if (spriteram_wr) begin
            exp_t e;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            n_wr++;
            check("wr_while_busy", {31'd0, dma_busy}, 32'd1);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write (cycle %0d)",
                         spriteram_wr_addr, spriteram_data_in, cyc);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {25'd0, spriteram_wr_addr}, {25'd0, e.addr});
                check("wr_data", {24'd0, spriteram_data_in}, {24'd0, e.data});
            end
        end
        if (dma_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic fill(input logic [15:0] b, input logic [7:0] key);
        for (int i = 0; i < 128; i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            mem[a] = 8'(i) ^ key;
        end
    endtask

    task automatic push_copy(input int n, input logic [7:0] key);
        for (int k = 0; k < n; k++) begin
            sb.push_back({7'(k), 8'(k) ^ key});
        end
    endtask

    task automatic start(input logic [15:0] b);
        @(negedge clk);
        cpu_start    = 1'b1;
        cpu_src_base = b;
        @(negedge clk);
        cpu_start    = 1'b0;
    endtask

    task automatic rise(output int t);
        @(negedge clk);
        first_wr = -1;
        last_wr  = -1;
        n_wr     = 0;
        vblank   = 1'b1;
        t        = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        check(name, done_cnt, d0 + 1);
    endtask

    task automatic drop_vblank();
        @(negedge clk);
        vblank = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int d0;
        int n0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_wr", {31'd0, spriteram_wr}, 32'd0);
        check("rst_armed", {31'd0, dma_armed}, 32'd0);
        check("rst_busy", {31'd0, dma_busy}, 32'd0);
        check("rst_done", {31'd0, dma_done}, 32'd0);
        check("rst_overrun", {31'd0, dma_overrun}, 32'd0);
        check("rst_src_addr", {16'd0, src_addr}, 32'd0);
        check("rst_wr_addr", {25'd0, spriteram_wr_addr}, 32'd0);
        check("rst_data_in", {24'd0, spriteram_data_in}, 32'd0);

        // Basic copy from 0x4000, byte k = k ^ 0x5A
        fill(16'h4000, 8'h5A);
        start(16'h4000);
        check("t1_armed", {31'd0, dma_armed}, 32'd1);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        rise(t);
        push_copy(128, 8'h5A);
        @(negedge clk);
        check("t1_busy", {31'd0, dma_busy}, 32'd1);
        check("t1_armed_clr", {31'd0, dma_armed}, 32'd0);
        check("t1_src_first", {16'd0, src_addr}, 32'h4000);
        wait_done(d0, "t1_done_pulse");
        check("t1_first_wr", first_wr, t + 2);
        check("t1_last_wr", last_wr, t + 129);
        check("t1_n_wr", n_wr, 128);
        check("t1_done_cyc", done_cyc, t + 130);
        check("t1_overrun", {31'd0, dma_overrun}, 32'd0);
        check("t1_armed_after", {31'd0, dma_armed}, 32'd0);
        check("t1_busy_after", {31'd0, dma_busy}, 32'd0);
        check("t1_sb_empty", sb.size(), 0);
        drop_vblank();

        // Re-arm: second base wins, strobe while busy ignored
        fill(16'h1000, 8'h11);
        fill(16'h2000, 8'h22);
        fill(16'h3000, 8'h33);
        start(16'h1000);
        repeat (2) @(negedge clk);
        start(16'h2000);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        rise(t);
        push_copy(128, 8'h22);
        wait_until(t + 50);
        cpu_start    = 1'b1;
        cpu_src_base = 16'h3000;
        @(negedge clk);
        cpu_start    = 1'b0;
        check("t2_armed_busy", {31'd0, dma_armed}, 32'd0);
        wait_done(d0, "t2_done_pulse");
        check("t2_n_wr", n_wr, 128);
        check("t2_armed_after", {31'd0, dma_armed}, 32'd0);
        drop_vblank();
        n0 = n_wr;
        d0 = done_cnt;
        @(negedge clk);
        vblank = 1'b1;
        repeat (150) @(negedge clk);
        check("t2_no_recopy", n_wr, n0);
        check("t2_no_done", done_cnt, d0);
        drop_vblank();

        // Source address wrap from 0xFFC0; byte 64 comes from 0x0000
        fill(16'hFFC0, 8'hC3);
        start(16'hFFC0);
        d0 = done_cnt;
        rise(t);
        push_copy(128, 8'hC3);
        wait_until(t + 1);
        check("t3_src_start", {16'd0, src_addr}, 32'hFFC0);
        wait_until(t + 64);
        check("t3_src_top", {16'd0, src_addr}, 32'hFFFF);
        wait_until(t + 65);
        check("t3_src_wrap", {16'd0, src_addr}, 32'h0000);
        wait_until(t + 66);
        check("t3_byte64", {24'd0, spriteram_data_in}, 32'h83);
        wait_until(t + 128);
        check("t3_src_end", {16'd0, src_addr}, 32'h003F);
        wait_done(d0, "t3_done_pulse");
        check("t3_n_wr", n_wr, 128);
        drop_vblank();

        // Overrun: vblank high for 60 cycles only
        start(16'h4000);
        d0 = done_cnt;
        rise(t);
        push_copy(128, 8'h5A);
        wait_until(t + 60);
        check("t4_overrun_early", {31'd0, dma_overrun}, 32'd0);
        vblank = 1'b0;
        @(negedge clk);
        check("t4_overrun_set", {31'd0, dma_overrun}, 32'd1);
        wait_done(d0, "t4_done_pulse");
        check("t4_n_wr", n_wr, 128);
        check("t4_done_cyc", done_cyc, t + 130);
        repeat (5) @(negedge clk);
        check("t4_overrun_sticky", {31'd0, dma_overrun}, 32'd1);
        start(16'h4000);
        check("t4_overrun_clr", {31'd0, dma_overrun}, 32'd0);
        check("t4_rearmed", {31'd0, dma_armed}, 32'd1);

        // Reset mid-copy at T+40
        d0 = done_cnt;
        rise(t);
        push_copy(39, 8'h5A);
        wait_until(t + 40);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_wr", {31'd0, spriteram_wr}, 32'd0);
        check("t5_busy", {31'd0, dma_busy}, 32'd0);
        check("t5_armed", {31'd0, dma_armed}, 32'd0);
        check("t5_src_addr", {16'd0, src_addr}, 32'd0);
        check("t5_wr_addr", {25'd0, spriteram_wr_addr}, 32'd0);
        check("t5_data_in", {24'd0, spriteram_data_in}, 32'd0);
        repeat (150) @(negedge clk);
        check("t5_n_wr", n_wr, 39);
        check("t5_no_done", done_cnt, d0);
        check("t5_sb_empty", sb.size(), 0);
        drop_vblank();
        @(negedge clk);
        vblank = 1'b1;
        repeat (150) @(negedge clk);
        check("t5_idle_rise", n_wr, 39);
        check("t5_idle_done", done_cnt, d0);
        drop_vblank();

`ifdef SPRITE_DMA_AUTO_EN
        // Auto mode: three frames from one strobe, then base 0 disarms
        start(16'h4000);
        d0 = done_cnt;
        for (int f = 0; f < 3; f++) begin
            rise(t);
            push_copy(128, 8'h5A);
            wait_done(d0 + f, "t6_done_pulse");
            check("t6_n_wr", n_wr, 128);
            @(negedge clk);
            check("t6_rearmed", {31'd0, dma_armed}, 32'd1);
            drop_vblank();
        end
        check("t6_done_total", done_cnt, d0 + 3);
        start(16'h0000);
        check("t6_disarmed", {31'd0, dma_armed}, 32'd0);
        rise(t);
        repeat (150) @(negedge clk);
        check("t6_no_copy", n_wr, 0);
        check("t6_no_done", done_cnt, d0 + 3);
        drop_vblank();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
